// File: rtl/cliff_move_sched.sv
// Movement scheduler and game sequencer for the cliff game: step tick, shift strobes, player index, game state.
// Optional CLIFF_WRAP_EN: edge overruns wrap the player index instead of losing.
module cliff_move_sched #(
    parameter logic [31:0] TICK_BASE = 32'd25_000_000,
    parameter logic [7:0]  START_IDX = 8'd7,
    parameter logic [7:0]  MAX_IDX   = 8'd15
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       btn_start,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       hit,
    output logic       load_start,
    output logic       step_left,
    output logic       step_right,
    output logic [7:0] pos,
    output logic [1:0] speed,
    output logic [1:0] dir,
    output logic [1:0] state,
    output logic       lose
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_PAUSE = 2'b10,
        S_LOSE  = 2'b11
    } state_e;

    localparam logic [1:0] DIR_STOP  = 2'b00;
    localparam logic [1:0] DIR_LEFT  = 2'b01;
    localparam logic [1:0] DIR_RIGHT = 2'b10;
    localparam logic [1:0] SPEED_MAX = 2'd3;

    state_e      state_q, state_d;
    logic [31:0] count_q, count_d;
    logic [7:0]  pos_q, pos_d;
    logic [1:0]  speed_q, speed_d;
    logic [1:0]  dir_q, dir_d;
    logic        load_q, load_d;
    logic        left_q, left_d;
    logic        right_q, right_d;
    logic        lose_q, lose_d;
    logic [31:0] reload_c;

    // Reload always uses the speed in force now; button changes land at the following reload.
    assign reload_c = (TICK_BASE >> speed_q) - 32'd1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            count_q <= '0;
            pos_q   <= START_IDX;
            speed_q <= '0;
            dir_q   <= DIR_STOP;
            load_q  <= 1'b0;
            left_q  <= 1'b0;
            right_q <= 1'b0;
            lose_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            pos_q   <= pos_d;
            speed_q <= speed_d;
            dir_q   <= dir_d;
            load_q  <= load_d;
            left_q  <= left_d;
            right_q <= right_d;
            lose_q  <= lose_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        pos_d   = pos_q;
        speed_d = speed_q;
        dir_d   = dir_q;
        load_d  = 1'b0;
        left_d  = 1'b0;
        right_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (btn_start) begin
                    state_d = S_RUN;
                    load_d  = 1'b1;
                    pos_d   = START_IDX;
                    dir_d   = DIR_STOP;
                    count_d = reload_c;
                end
            end
            S_RUN: begin
                if (hit) begin
                    state_d = S_LOSE;
                end else if (btn_start) begin
                    state_d = S_PAUSE;
                end else begin
                    // Tick acts on the pre-update direction.
                    if (count_q == '0) begin
                        count_d = reload_c;
                        if (dir_q == DIR_LEFT) begin
                            if (pos_q < MAX_IDX) begin
                                left_d = 1'b1;
                                pos_d  = pos_q + 8'd1;
                            end else begin
`ifdef CLIFF_WRAP_EN
                                left_d = 1'b1;
                                pos_d  = '0;
`else
                                state_d = S_LOSE;
`endif
                            end
                        end else if (dir_q == DIR_RIGHT) begin
                            if (pos_q > 8'd0) begin
                                right_d = 1'b1;
                                pos_d   = pos_q - 8'd1;
                            end else begin
`ifdef CLIFF_WRAP_EN
                                right_d = 1'b1;
                                pos_d   = MAX_IDX;
`else
                                state_d = S_LOSE;
`endif
                            end
                        end
                    end else begin
                        count_d = count_q - 32'd1;
                    end

                    if (btn_left && btn_right) begin
                        dir_d = DIR_STOP;
                    end else if (btn_left) begin
                        dir_d = DIR_LEFT;
                    end else if (btn_right) begin
                        dir_d = DIR_RIGHT;
                    end

                    if (btn_up && !btn_down && (speed_q != SPEED_MAX)) begin
                        speed_d = speed_q + 2'd1;
                    end else if (btn_down && !btn_up && (speed_q != 2'd0)) begin
                        speed_d = speed_q - 2'd1;
                    end
                end
            end
            S_PAUSE: begin
                if (btn_start) begin
                    state_d = S_RUN;
                end
            end
            S_LOSE: begin
                if (btn_start) begin
                    state_d = S_IDLE;
                    speed_d = '0;
                    dir_d   = DIR_STOP;
                    pos_d   = START_IDX;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        lose_d = (state_d == S_LOSE);
    end

    assign load_start = load_q;
    assign step_left  = left_q;
    assign step_right = right_q;
    assign pos        = pos_q;
    assign speed      = speed_q;
    assign dir        = dir_q;
    assign state      = state_q;
    assign lose       = lose_q;

endmodule

// File: tb/tb_cliff_move_sched.sv
// Bench for cliff_move_sched: hand-derived vector table, corner sequences and a randomized run against a cycle model.
module tb_cliff_move_sched;

    localparam int TICK = 8;
    localparam int START = 7;
    localparam int MAXI = 15;

    localparam logic [5:0] B_0  = 6'b000000;
    localparam logic [5:0] B_ST = 6'b100000;
    localparam logic [5:0] B_L  = 6'b010000;
    localparam logic [5:0] B_R  = 6'b001000;
    localparam logic [5:0] B_U  = 6'b000100;
    localparam logic [5:0] B_D  = 6'b000010;
    localparam logic [5:0] B_H  = 6'b000001;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    logic btn_start = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
    logic btn_up = 1'b0, btn_down = 1'b0, hit = 1'b0;
    logic load_start, step_left, step_right, lose;
    logic [7:0] pos;
    logic [1:0] speed, dir, state;
    logic [17:0] dut_vec;

    assign dut_vec = {load_start, step_left, step_right, pos, speed, dir, state, lose};

    cliff_move_sched #(
        .TICK_BASE(32'd8),
        .START_IDX(8'd7),
        .MAX_IDX  (8'd15)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .btn_start (btn_start),
        .btn_left  (btn_left),
        .btn_right (btn_right),
        .btn_up    (btn_up),
        .btn_down  (btn_down),
        .hit       (hit),
        .load_start(load_start),
        .step_left (step_left),
        .step_right(step_right),
        .pos       (pos),
        .speed     (speed),
        .dir       (dir),
        .state     (state),
        .lose      (lose)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    // Reference model: game mode 0 idle, 1 run, 2 pause, 3 lose; cnt = cycles left before the next step.
    int  m_state, m_pos, m_speed, m_dir, m_cnt;
    bit  m_load, m_sl, m_sr;

    typedef struct {
        bit          rst;
        logic [5:0]  btn;
        int          idle;
        logic [17:0] exp;
        string       name;
    } vec_t;
    vec_t tbl[$];

    task automatic check(input string nm, input logic [17:0] act, input logic [17:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got ld/sl/sr/pos/spd/dir/st/lose=%b/%b/%b/%0d/%0d/%0d/%0d/%b want %b/%b/%b/%0d/%0d/%0d/%0d/%b",
                      nm, act[17], act[16], act[15], act[14:7], act[6:5], act[4:3], act[2:1], act[0],
                      exp[17], exp[16], exp[15], exp[14:7], exp[6:5], exp[4:3], exp[2:1], exp[0]);
    endtask

    function automatic logic [17:0] ex(input bit ld, input bit sl, input bit sr,
                                       input int p, input int sp, input int dr, input int st);
        return {ld, sl, sr, 8'(p), 2'(sp), 2'(dr), 2'(st), (st == 3)};
    endfunction

    function automatic logic [17:0] model_vec();
        return ex(m_load, m_sl, m_sr, m_pos, m_speed, m_dir, m_state);
    endfunction

    function automatic int period(input int s);
        return TICK / (2 ** s);
    endfunction

    task automatic model_reset();
        m_state = 0; m_pos = START; m_speed = 0; m_dir = 0; m_cnt = 0;
        m_load = 0; m_sl = 0; m_sr = 0;
    endtask

    task automatic model_step(input logic [5:0] b);
        bit st, l, r, u, d, h;
        int delta, target;
        {st, l, r, u, d, h} = b;
        m_load = 0; m_sl = 0; m_sr = 0;
        case (m_state)
            0: if (st) begin
                m_state = 1; m_load = 1; m_pos = START; m_dir = 0;
                m_cnt = period(m_speed) - 1;
            end
            1: if (h) m_state = 3;
            else if (st) m_state = 2;
            else begin
                if (m_cnt == 0) begin
                    m_cnt = period(m_speed) - 1;
                    delta = (m_dir == 1) ? 1 : (m_dir == 2) ? -1 : 0;
                    target = m_pos + delta;
                    if (delta != 0) begin
`ifdef CLIFF_WRAP_EN
                        m_pos = (target + MAXI + 1) % (MAXI + 1);
                        m_sl = (delta > 0); m_sr = (delta < 0);
`else
                        if (target >= 0 && target <= MAXI) begin
                            m_pos = target; m_sl = (delta > 0); m_sr = (delta < 0);
                        end else m_state = 3;
`endif
                    end
                end else m_cnt = m_cnt - 1;
                if (l && r) m_dir = 0;
                else if (l) m_dir = 1;
                else if (r) m_dir = 2;
                m_speed = m_speed + int'(u) - int'(d);
                if (m_speed > 3) m_speed = 3;
                if (m_speed < 0) m_speed = 0;
            end
            2: if (st) m_state = 1;
            default: if (st) begin
                m_state = 0; m_speed = 0; m_dir = 0; m_pos = START;
            end
        endcase
    endtask

    // One clock: drive buttons, step the model, compare after the edge.
    task automatic cycle(input logic [5:0] b);
        {btn_start, btn_left, btn_right, btn_up, btn_down, hit} = b;
        @(posedge clk);
        #1;
        model_step(b);
        check("model", dut_vec, model_vec());
        {btn_start, btn_left, btn_right, btn_up, btn_down, hit} = B_0;
    endtask

    task automatic do_reset();
        {btn_start, btn_left, btn_right, btn_up, btn_down, hit} = B_0;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_reset();
    endtask

    task automatic add(input bit r, input logic [5:0] b, input int idl, input logic [17:0] e, input string nm);
        vec_t v;
        v.rst = r; v.btn = b; v.idle = idl; v.exp = e; v.name = nm;
        tbl.push_back(v);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        #2 reset_n = 1'b0;
        #1 check("reset_vals", dut_vec, ex(0, 0, 0, 7, 0, 0, 0));

        // Walk left to the edge.
        add(1, B_ST, 0,  ex(1, 0, 0, 7, 0, 0, 1), "start");
        add(0, B_0,  0,  ex(0, 0, 0, 7, 0, 0, 1), "start_one_cycle");
        add(0, B_L,  0,  ex(0, 0, 0, 7, 0, 1, 1), "dir_left");
        add(0, B_0,  5,  ex(0, 1, 0, 8, 0, 1, 1), "first_step");
        add(0, B_0,  0,  ex(0, 0, 0, 8, 0, 1, 1), "strobe_one_cycle");
        add(0, B_0,  6,  ex(0, 1, 0, 9, 0, 1, 1), "step_9");
        add(0, B_0,  47, ex(0, 1, 0, 15, 0, 1, 1), "step_15");
`ifdef CLIFF_WRAP_EN
        add(0, B_0,  7,  ex(0, 1, 0, 0, 0, 1, 1), "wrap_left");
`else
        add(0, B_0,  7,  ex(0, 0, 0, 15, 0, 1, 3), "lose_left_edge");
        add(0, B_ST, 0,  ex(0, 0, 0, 7, 0, 0, 0), "lose_to_idle");
`endif
        // Speed saturation and one-cycle period, running right.
        add(1, B_ST,      0, ex(1, 0, 0, 7, 0, 0, 1), "start_b");
        add(0, B_U,       0, ex(0, 0, 0, 7, 1, 0, 1), "speed_1");
        add(0, B_U,       0, ex(0, 0, 0, 7, 2, 0, 1), "speed_2");
        add(0, B_U | B_D, 0, ex(0, 0, 0, 7, 2, 0, 1), "up_down_same");
        add(0, B_U,       0, ex(0, 0, 0, 7, 3, 0, 1), "speed_3");
        add(0, B_U,       0, ex(0, 0, 0, 7, 3, 0, 1), "speed_sat_a");
        add(0, B_U,       0, ex(0, 0, 0, 7, 3, 0, 1), "speed_sat_b");
        add(0, B_R,       0, ex(0, 0, 0, 7, 3, 2, 1), "dir_right");
        add(0, B_0,       0, ex(0, 0, 1, 6, 3, 2, 1), "fast_step_a");
        add(0, B_0,       0, ex(0, 0, 1, 5, 3, 2, 1), "fast_step_b");
        add(0, B_0,       3, ex(0, 0, 1, 1, 3, 2, 1), "fast_step_c");
        add(0, B_D,       0, ex(0, 0, 1, 0, 2, 2, 1), "step_and_slow");
`ifdef CLIFF_WRAP_EN
        add(0, B_0,       0, ex(0, 0, 1, 15, 2, 2, 1), "wrap_right");
        add(0, B_0,       0, ex(0, 0, 0, 15, 2, 2, 1), "slower_reload");
        add(0, B_0,       0, ex(0, 0, 1, 14, 2, 2, 1), "after_wrap");
`else
        add(0, B_0,       0, ex(0, 0, 0, 0, 2, 2, 3), "lose_right_edge");
        add(0, B_ST,      0, ex(0, 0, 0, 7, 0, 0, 0), "lose_clears");
`endif
        // Idle ignores everything but start.
        add(1, B_L | B_R | B_U | B_D | B_H, 2, ex(0, 0, 0, 7, 0, 0, 0), "idle_ignores");
        // Hit coinciding with a tick.
        add(1, B_ST,      0, ex(1, 0, 0, 7, 0, 0, 1), "start_d");
        add(0, B_L,       0, ex(0, 0, 0, 7, 0, 1, 1), "dir_left_d");
        add(0, B_0,       5, ex(0, 0, 0, 7, 0, 1, 1), "before_tick");
        add(0, B_H,       0, ex(0, 0, 0, 7, 0, 1, 3), "hit_on_tick");
        add(0, B_L | B_H, 1, ex(0, 0, 0, 7, 0, 1, 3), "lose_holds");
        add(0, B_ST,      0, ex(0, 0, 0, 7, 0, 0, 0), "lose_restart");
        // Pause at count 5, resume, step six cycles later.
        add(1, B_ST,            0,  ex(1, 0, 0, 7, 0, 0, 1), "start_e");
        add(0, B_L,             0,  ex(0, 0, 0, 7, 0, 1, 1), "dir_left_e");
        add(0, B_0,             0,  ex(0, 0, 0, 7, 0, 1, 1), "count_5");
        add(0, B_ST,            0,  ex(0, 0, 0, 7, 0, 1, 2), "pause");
        add(0, B_0,             19, ex(0, 0, 0, 7, 0, 1, 2), "pause_hold");
        add(0, B_R | B_U | B_H, 0,  ex(0, 0, 0, 7, 0, 1, 2), "pause_ignores");
        add(0, B_ST,            0,  ex(0, 0, 0, 7, 0, 1, 1), "resume");
        add(0, B_0,             4,  ex(0, 0, 0, 7, 0, 1, 1), "resume_5");
        add(0, B_0,             0,  ex(0, 1, 0, 8, 0, 1, 1), "resume_6");

        foreach (tbl[i]) begin
            if (tbl[i].rst) do_reset();
            cycle(tbl[i].btn);
            for (int k = 0; k < tbl[i].idle; k++) cycle(B_0);
            check(tbl[i].name, dut_vec, tbl[i].exp);
        end

        // Asynchronous reset mid-run with dir left and speed 2.
        do_reset();
        cycle(B_ST);
        cycle(B_L);
        cycle(B_U);
        cycle(B_U);
        check("pre_reset", dut_vec, ex(0, 0, 0, 7, 2, 1, 1));
        #3 reset_n = 1'b0;
        #1 check("async_reset", dut_vec, ex(0, 0, 0, 7, 0, 0, 0));
        model_reset();
        @(posedge clk);
        #1 reset_n = 1'b1;
        for (int k = 0; k < 5; k++) cycle(B_L | B_U);
        check("idle_after_reset", dut_vec, ex(0, 0, 0, 7, 0, 0, 0));
        cycle(B_ST);
        check("restart", dut_vec, ex(1, 0, 0, 7, 0, 0, 1));

        // Randomized play against the model.
        do_reset();
        for (int n = 0; n < 4000; n++) begin
            logic [5:0] b;
            b[5] = ($urandom_range(0, 29) == 0);
            b[4] = ($urandom_range(0, 9) == 0);
            b[3] = ($urandom_range(0, 9) == 0);
            b[2] = ($urandom_range(0, 11) == 0);
            b[1] = ($urandom_range(0, 11) == 0);
            b[0] = ($urandom_range(0, 79) == 0);
            cycle(b);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
